down_timer4: RTL

DOWN_TIMER4 -- requirements
Module: down_timer4

---
 rtl/down_timer4_pkg.sv | 12 +
 rtl/down_timer4_sub_bout.sv | 20 ++
 rtl/down_timer4.sv | 107 ++++++++++
 3 files changed

// File: rtl/down_timer4_pkg.sv
// rtl/down_timer4_pkg.sv - shared timer package: state encoding and default width
package down_timer4_pkg;

    localparam int DT_DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } dt_state_t;

endpackage

// File: rtl/down_timer4_sub_bout.sv
// rtl/down_timer4_sub_bout.sv - subtract-by-constant with borrow out
module sub_bout
    import down_timer4_pkg::*;
#(
    parameter int               WIDTH = DT_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] SUB   = WIDTH'(1)
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    // One extra bit catches the borrow; it is set exactly when a < SUB.
    logic [WIDTH:0] full;

    assign full = {1'b0, a} - {1'b0, SUB};
    assign diff = full[WIDTH-1:0];
    assign bout = full[WIDTH];

endmodule

// File: rtl/down_timer4.sv
// rtl/down_timer4.sv - loadable down-counter with one-shot / auto-reload modes
module down_timer4
    import down_timer4_pkg::*;
#(
    parameter int WIDTH = DT_DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    input  logic             CLEAR,
    input  logic             LOAD_VALID,
    output logic             LOAD_READY,
    input  logic [WIDTH-1:0] LOAD_DATA,
    input  logic             AUTO_RELOAD,
    input  logic             HALT,
    output logic [WIDTH-1:0] O,
    output logic             BOUT,
    output logic             BUSY
);

    dt_state_t        state_q;
    dt_state_t        state_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] reload_q;
    logic             mode_q;
    logic             bout_q;

    logic [WIDTH-1:0] count_dec;
    logic             count_borrow;
    logic             handshake;
    logic             tick;
    logic             terminal;

    // Decrement path; the borrow flags the count sitting at zero.
    sub_bout #(
        .WIDTH (WIDTH),
        .SUB   (WIDTH'(1))
    ) u_sub_bout (
        .a    (count_q),
        .diff (count_dec),
        .bout (count_borrow)
    );

    assign handshake = LOAD_VALID && LOAD_READY;
    assign tick      = (state_q == ST_RUN) && !HALT;
    assign terminal  = tick && count_borrow;

    // State register.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: CLEAR wins, then a load, then a one-shot terminal.
    always_comb begin
        state_d = state_q;
        if (CLEAR) begin
            state_d = ST_IDLE;
        end else if (handshake) begin
            state_d = ST_RUN;
        end else if (terminal && !mode_q) begin
            state_d = ST_DONE;
        end
    end

    // Outputs decoded from state; loads are refused while running or clearing.
    always_comb begin
        LOAD_READY = (state_q != ST_RUN) && !CLEAR;
        BUSY       = (state_q == ST_RUN);
    end

    // Count, reload value, mode and borrow pulse registers.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            count_q  <= '0;
            reload_q <= '0;
            mode_q   <= 1'b0;
            bout_q   <= 1'b0;
        end else if (CLEAR) begin
            count_q <= '0;
            mode_q  <= 1'b0;
            bout_q  <= 1'b0;
        end else if (handshake) begin
            count_q  <= LOAD_DATA;
            reload_q <= LOAD_DATA;
            mode_q   <= AUTO_RELOAD;
            bout_q   <= 1'b0;
        end else if (terminal) begin
            // One-shot leaves the count parked at zero.
            bout_q <= 1'b1;
            if (mode_q) begin
                count_q <= reload_q;
            end
        end else if (tick) begin
            count_q <= count_dec;
            bout_q  <= 1'b0;
        end else begin
            bout_q <= 1'b0;
        end
    end

    assign O    = count_q;
    assign BOUT = bout_q;

endmodule
